apb_protocol_monitor: RTL and testbench
=======================================

Name: apb_protocol_monitor

Overview:
- Parametrised, synthesizable APB3/APB4 protocol monitor. It is the successor to the single-assertion reset checker.
- Passively observes one APB bus with NO_SLAVES select lines and tracks the IDLE/SETUP/ACCESS phases.
- Flags protocol violations in a sticky error register and keeps saturating transfer statistics.
- Instantiated alongside the slave in the testbench top; it is also usable on silicon for debug.

Parameters:
- DATA_WIDTH, 32, PWDATA/PRDATA width.
- ADDR_WIDTH, 32, PADDR width.
- NO_SLAVES, 1, number of PSEL lines monitored (≥1).
- MAX_WAIT, 16, maximum ACCESS wait cycles (PREADY low) before a timeout is flagged.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- PCLK  in  1  bus clock; all sampling on rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PADDR  in  ADDR_WIDTH  bus address.
- PWRITE  in  1  direction: 1 = write.
- PWDATA  in  DATA_WIDTH  write data.
- PENABLE  in  1  access phase strobe.
- PSEL  in  NO_SLAVES  slave selects.
- PREADY  in  1  slave ready.
- PRDATA  in  DATA_WIDTH  read data.
- PSLVERR  in  1  slave error.
- clear_i  in  1  synchronous clear of sticky flags and counters.
- err_flags_o  out  8  sticky violation flags.
- err_pulse_o  out  1  one-cycle pulse when any violation is detected.
- first_err_o  out  3  index of the first violation since reset/clear.
- state_o  out  2  monitor phase: 0 IDLE, 1 SETUP, 2 ACCESS.
- wr_count_o  out  CNT_WIDTH  completed writes.
- rd_count_o  out  CNT_WIDTH  completed reads.
- slverr_count_o  out  CNT_WIDTH  completed transfers with PSLVERR.

Behaviour:
- Reset (PRESETn low, asynchronous): all outputs 0, state IDLE, post_rst flag set.
- sel = OR of PSEL. All checks use values sampled at the PCLK rise. Flag bits and err_pulse_o update one cycle after the offending sample.
- FSM transitions:
  - IDLE: sel & !PENABLE → SETUP, capturing PADDR, PWRITE, PWDATA and PSEL. sel & PENABLE → set bit1 (ENABLE_NO_SETUP), stay IDLE.
  - SETUP: sel & PENABLE → ACCESS, or complete immediately if PREADY. Otherwise set bit2 (SETUP_NO_ACCESS); then go to SETUP with re-capture if sel, else IDLE.
  - ACCESS: PREADY → transfer complete, then go to SETUP (back-to-back) if sel & !PENABLE, else IDLE. !PENABLE or !sel before PREADY → set bit7 (ABORTED_ACCESS), go to IDLE.
- Per-cycle checks:
  - bit0 ONEHOT: more than one PSEL bit set, checked in any state.
  - bit3 UNSTABLE: in ACCESS, or SETUP→ACCESS, PADDR, PWRITE or PSEL differs from captured; PWDATA also compared when captured PWRITE=1.
  - bit6 SLVERR_OUTSIDE: PSLVERR high on any cycle that is not a completing access.
- Timeout (bit4): the wait counter increments each ACCESS cycle with PREADY low and saturates. Bit4 is set once, when the count reaches MAX_WAIT. The counter resets on completion or on IDLE.
- RESET_RDATA (bit5): on the first PCLK rise after PRESETn deassertion, PRDATA ≠ 0 → set; post_rst then clears.
- Completion: increment wr_count_o or rd_count_o by captured PWRITE; increment slverr_count_o if PSLVERR. All counters saturate at all-ones.
- Sticky register, first_err_o and clear_i:
  - first_err_o loads the lowest set index of the first violating cycle while err_flags_o == 0.
  - clear_i zeroes flags, first_err_o and counters.
  - Simultaneous clear and event: the new event survives, so counter = 1 and the flag is set.
- Reset mid-transfer: state returns to IDLE asynchronously and no violation is recorded for the truncated transfer.

Decomposition:
- apb_mon_pkg: state enum (IDLE, SETUP, ACCESS); localparams for error bit indices 0–7; ERR_W = 8.
- Sub-module apb_mon_sat_cnt (parameter W; inc, clr; saturating, clr-then-inc semantics). Instantiate four times: three statistics counters plus the wait counter.

Test Plan:
- Reset with PRDATA = 32'hDEAD_BEEF on release → err_flags_o = 8'h20, first_err_o = 5, err_pulse_o one cycle.
- Legal write (addr 0x10, data 0xA5, 2 wait states) then read with PSLVERR=1 → flags 0, wr=1, rd=1, slverr=1.
- PENABLE high with PSEL in IDLE, then PADDR changes 0x10→0x14 during ACCESS wait → flags bits1 and 3, first_err_o = 1.
- PREADY held low 20 cycles, MAX_WAIT=16 → bit4 set exactly once, 16 ACCESS wait cycles after entry; err_pulse_o single pulse.
- NO_SLAVES=4, PSEL=4'b0101 → bit0; clear_i the same cycle a write completes → flags=1, wr_count=1.
- Five back-to-back reads without an IDLE gap → no flags, rd_count=5; a read with CNT_WIDTH=2 saturates at 3.

Source files
------------

// File: rtl/apb_mon_pkg.sv
// apb_mon_pkg: shared types and constants for the APB protocol monitor.
// Holds the monitor phase encoding, the violation bit map and a helper
// that picks the lowest set violation index.
package apb_mon_pkg;

  // Monitor phase as seen on the bus at the last sampled edge.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  // Width of the sticky violation register.
  localparam int ERR_W = 8;

  // Violation bit positions inside err_flags_o.
  localparam int ERR_ONEHOT          = 0;
  localparam int ERR_ENABLE_NO_SETUP = 1;
  localparam int ERR_SETUP_NO_ACCESS = 2;
  localparam int ERR_UNSTABLE        = 3;
  localparam int ERR_TIMEOUT         = 4;
  localparam int ERR_RESET_RDATA     = 5;
  localparam int ERR_SLVERR_OUTSIDE  = 6;
  localparam int ERR_ABORTED_ACCESS  = 7;

  // Index of the lowest set bit; 0 when nothing is set (callers only use
  // the result when at least one bit is set).
  function automatic logic [2:0] lowest_set(input logic [ERR_W-1:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = ERR_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/apb_mon_sat_cnt.sv
// apb_mon_sat_cnt: W-bit saturating up-counter with synchronous clear.
// A clear and an increment in the same cycle leave the counter at 1, so an
// event coinciding with a clear is never lost.
module apb_mon_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;
  logic [W-1:0] base_s;
  logic [W-1:0] count_nxt_s;

  // Next value: apply the clear first, then a non-wrapping increment.
  always_comb begin
    base_s      = {W{1'b0}};
    count_nxt_s = {W{1'b0}};
    if (clr) begin
      base_s = {W{1'b0}};
    end else begin
      base_s = count_r;
    end
    if (inc && (base_s != {W{1'b1}})) begin
      count_nxt_s = base_s + W'(1'b1);
    end else begin
      count_nxt_s = base_s;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/apb_protocol_monitor.sv
// apb_protocol_monitor: passive APB3/APB4 bus observer.
// Follows the IDLE/SETUP/ACCESS phases of one bus, records protocol
// violations in a sticky register (with a one-cycle pulse and the index of
// the first violation) and keeps saturating transfer statistics.
module apb_protocol_monitor
  import apb_mon_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NO_SLAVES  = 1,
  parameter int MAX_WAIT   = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic                  PWRITE,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PENABLE,
  input  logic [NO_SLAVES-1:0]  PSEL,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR,
  input  logic                  clear_i,
  output logic [7:0]            err_flags_o,
  output logic                  err_pulse_o,
  output logic [2:0]            first_err_o,
  output logic [1:0]            state_o,
  output logic [CNT_WIDTH-1:0]  wr_count_o,
  output logic [CNT_WIDTH-1:0]  rd_count_o,
  output logic [CNT_WIDTH-1:0]  slverr_count_o
);

  // Wide enough to hold MAX_WAIT so the timeout compare can be reached.
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  // True when more than one select line is active.
  function automatic logic multi_hot(input logic [NO_SLAVES-1:0] vec);
    return ((vec & (vec - NO_SLAVES'(1'b1))) != {NO_SLAVES{1'b0}});
  endfunction

  apb_state_e state_r;
  apb_state_e state_nxt_s;

  logic                  sel_s;
  logic                  access_s;
  logic                  capture_s;
  logic                  complete_s;
  logic                  wait_inc_s;
  logic                  stable_chk_s;
  logic                  mismatch_s;
  logic                  enable_no_setup_s;
  logic                  setup_no_access_s;
  logic                  aborted_s;
  logic                  timeout_s;

  logic [ADDR_WIDTH-1:0] cap_addr_r;
  logic                  cap_write_r;
  logic [DATA_WIDTH-1:0] cap_wdata_r;
  logic [NO_SLAVES-1:0]  cap_sel_r;

  logic                  post_rst_r;
  logic [WAIT_W-1:0]     wait_cnt_s;

  logic [ERR_W-1:0]      viol_s;
  logic [ERR_W-1:0]      flags_base_s;
  logic [ERR_W-1:0]      err_flags_nxt_s;
  logic [ERR_W-1:0]      err_flags_r;
  logic [2:0]            first_base_s;
  logic [2:0]            first_err_nxt_s;
  logic [2:0]            first_err_r;
  logic                  err_pulse_r;

  assign sel_s    = (PSEL != {NO_SLAVES{1'b0}});
  assign access_s = sel_s & PENABLE;

  // Phase tracking. A pending transfer (SETUP or ACCESS) expects an access
  // sample; a completing access returns to IDLE, and a back-to-back setup is
  // then picked up from IDLE on the following sample.
  always_comb begin
    state_nxt_s       = state_r;
    capture_s         = 1'b0;
    complete_s        = 1'b0;
    wait_inc_s        = 1'b0;
    stable_chk_s      = 1'b0;
    enable_no_setup_s = 1'b0;
    setup_no_access_s = 1'b0;
    aborted_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (access_s) begin
          enable_no_setup_s = 1'b1;
          state_nxt_s       = ST_IDLE;
        end else if (sel_s) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_SETUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (access_s) begin
          stable_chk_s = 1'b1;
          if (PREADY) begin
            complete_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            wait_inc_s  = 1'b1;
            state_nxt_s = ST_ACCESS;
          end
        end else begin
          setup_no_access_s = 1'b1;
          if (sel_s) begin
            capture_s   = 1'b1;
            state_nxt_s = ST_SETUP;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
      end
      ST_ACCESS: begin
        if (access_s) begin
          stable_chk_s = 1'b1;
          if (PREADY) begin
            complete_s  = 1'b1;
            state_nxt_s = ST_IDLE;
          end else begin
            wait_inc_s  = 1'b1;
            state_nxt_s = ST_ACCESS;
          end
        end else begin
          aborted_s   = 1'b1;
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Phase register.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Setup-phase snapshot used for the stability check and for the
  // read/write decision at completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cap_addr_r  <= {ADDR_WIDTH{1'b0}};
      cap_write_r <= 1'b0;
      cap_wdata_r <= {DATA_WIDTH{1'b0}};
      cap_sel_r   <= {NO_SLAVES{1'b0}};
    end else if (capture_s) begin
      cap_addr_r  <= PADDR;
      cap_write_r <= PWRITE;
      cap_wdata_r <= PWDATA;
      cap_sel_r   <= PSEL;
    end else begin
      cap_addr_r  <= cap_addr_r;
      cap_write_r <= cap_write_r;
      cap_wdata_r <= cap_wdata_r;
      cap_sel_r   <= cap_sel_r;
    end
  end

  // Marks the first sampled edge after reset release for the PRDATA check.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      post_rst_r <= 1'b1;
    end else begin
      post_rst_r <= 1'b0;
    end
  end

  // Counts access-phase samples with PREADY low; any other sample restarts it.
  apb_mon_sat_cnt #(.W(WAIT_W)) u_wait_cnt (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clr   (~wait_inc_s),
    .inc   (wait_inc_s),
    .count (wait_cnt_s)
  );

  // Compare the bus against the setup snapshot; write data only matters
  // for writes.
  always_comb begin
    mismatch_s = 1'b0;
    if ((PADDR != cap_addr_r) || (PWRITE != cap_write_r) || (PSEL != cap_sel_r)) begin
      mismatch_s = 1'b1;
    end else if (cap_write_r && (PWDATA != cap_wdata_r)) begin
      mismatch_s = 1'b1;
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // The timeout fires only on the wait sample that brings the count to
  // MAX_WAIT, so a long stall raises it exactly once.
  assign timeout_s = wait_inc_s & (wait_cnt_s == WAIT_W'(MAX_WAIT - 1));

  // Collect this sample's violations.
  always_comb begin
    viol_s                      = {ERR_W{1'b0}};
    viol_s[ERR_ONEHOT]          = multi_hot(PSEL);
    viol_s[ERR_ENABLE_NO_SETUP] = enable_no_setup_s;
    viol_s[ERR_SETUP_NO_ACCESS] = setup_no_access_s;
    viol_s[ERR_UNSTABLE]        = stable_chk_s & mismatch_s;
    viol_s[ERR_TIMEOUT]         = timeout_s;
    viol_s[ERR_RESET_RDATA]     = post_rst_r & (PRDATA != {DATA_WIDTH{1'b0}});
    viol_s[ERR_SLVERR_OUTSIDE]  = PSLVERR & ~complete_s;
    viol_s[ERR_ABORTED_ACCESS]  = aborted_s;
  end

  // Sticky flags and first-error capture: clear first, then merge this
  // sample's violations so a coincident event survives the clear.
  always_comb begin
    flags_base_s    = {ERR_W{1'b0}};
    first_base_s    = 3'd0;
    err_flags_nxt_s = {ERR_W{1'b0}};
    first_err_nxt_s = 3'd0;
    if (clear_i) begin
      flags_base_s = {ERR_W{1'b0}};
      first_base_s = 3'd0;
    end else begin
      flags_base_s = err_flags_r;
      first_base_s = first_err_r;
    end
    err_flags_nxt_s = flags_base_s | viol_s;
    if ((flags_base_s == {ERR_W{1'b0}}) && (viol_s != {ERR_W{1'b0}})) begin
      first_err_nxt_s = lowest_set(viol_s);
    end else begin
      first_err_nxt_s = first_base_s;
    end
  end

  // Error reporting registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err_flags_r <= {ERR_W{1'b0}};
      first_err_r <= 3'd0;
      err_pulse_r <= 1'b0;
    end else begin
      err_flags_r <= err_flags_nxt_s;
      first_err_r <= first_err_nxt_s;
      err_pulse_r <= (viol_s != {ERR_W{1'b0}});
    end
  end

  // Transfer statistics.
  apb_mon_sat_cnt #(.W(CNT_WIDTH)) u_wr_cnt (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clr   (clear_i),
    .inc   (complete_s & cap_write_r),
    .count (wr_count_o)
  );

  apb_mon_sat_cnt #(.W(CNT_WIDTH)) u_rd_cnt (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clr   (clear_i),
    .inc   (complete_s & ~cap_write_r),
    .count (rd_count_o)
  );

  apb_mon_sat_cnt #(.W(CNT_WIDTH)) u_slverr_cnt (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .clr   (clear_i),
    .inc   (complete_s & PSLVERR),
    .count (slverr_count_o)
  );

  assign err_flags_o = err_flags_r;
  assign err_pulse_o = err_pulse_r;
  assign first_err_o = first_err_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_apb_protocol_monitor.sv
// tb_apb_protocol_monitor: directed bench for apb_protocol_monitor.
// Two monitors watch the same bus (16-bit and 2-bit statistics counters).
// A transfer-level reference model tracks the expected outputs every cycle;
// literal expectations at the end of each scenario pin the model.
module tb_apb_protocol_monitor;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NS  = 4;
  localparam int MW  = 16;
  localparam int CWA = 16;
  localparam int CWB = 2;

  logic          PCLK    = 1'b0;
  logic          PRESETn = 1'b1;
  logic [AW-1:0] PADDR   = '0;
  logic          PWRITE  = 1'b0;
  logic [DW-1:0] PWDATA  = '0;
  logic          PENABLE = 1'b0;
  logic [NS-1:0] PSEL    = '0;
  logic          PREADY  = 1'b0;
  logic [DW-1:0] PRDATA  = '0;
  logic          PSLVERR = 1'b0;
  logic          clear_i = 1'b0;

  logic [7:0]     flags_a, flags_b;
  logic           pulse_a, pulse_b;
  logic [2:0]     first_a, first_b;
  logic [1:0]     st_a, st_b;
  logic [CWA-1:0] wr_a, rd_a, se_a;
  logic [CWB-1:0] wr_b, rd_b, se_b;

  int n_vec = 0;
  int n_err = 0;
  int pulse_seen = 0;

  // Reference model state (transfer level).
  int            m_stage = 0;   // 0 no transfer, 1 setup seen, 2 waiting in access
  int            m_waits = 0;   // access-phase samples with PREADY low
  bit            m_post_rst = 1'b1;
  int            m_wr = 0, m_rd = 0, m_se = 0;
  logic [7:0]    m_flags = 8'h00;
  logic [2:0]    m_first = 3'd0;
  bit            m_pulse = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic          c_wr = 1'b0;
  logic [DW-1:0] c_data = '0;
  logic [NS-1:0] c_sel = '0;

  always #5 PCLK = ~PCLK;

  apb_protocol_monitor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NO_SLAVES(NS),
                         .MAX_WAIT(MW), .CNT_WIDTH(CWA)) dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR), .clear_i(clear_i),
    .err_flags_o(flags_a), .err_pulse_o(pulse_a), .first_err_o(first_a),
    .state_o(st_a), .wr_count_o(wr_a), .rd_count_o(rd_a), .slverr_count_o(se_a)
  );

  apb_protocol_monitor #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NO_SLAVES(NS),
                         .MAX_WAIT(MW), .CNT_WIDTH(CWB)) dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PENABLE(PENABLE), .PSEL(PSEL), .PREADY(PREADY),
    .PRDATA(PRDATA), .PSLVERR(PSLVERR), .clear_i(clear_i),
    .err_flags_o(flags_b), .err_pulse_o(pulse_b), .first_err_o(first_b),
    .state_o(st_b), .wr_count_o(wr_b), .rd_count_o(rd_b), .slverr_count_o(se_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input int v, input int w);
    logic [63:0] lim;
    lim = (64'd1 << w) - 64'd1;
    if (64'(v) > lim) return lim;
    else return 64'(v);
  endfunction

  // Apply the protocol rules to one sampled bus cycle.
  task automatic model_step();
    logic [7:0] v;
    bit done;
    bit sel;
    int nxt;
    v = 8'h00; done = 1'b0; nxt = 0;
    sel = (PSEL != 4'b0000);
    if (!PRESETn) begin
      m_stage = 0; m_waits = 0; m_post_rst = 1'b1;
      m_wr = 0; m_rd = 0; m_se = 0;
      m_flags = 8'h00; m_first = 3'd0; m_pulse = 1'b0;
      return;
    end
    if (m_post_rst && (PRDATA != 32'h0)) v[5] = 1'b1;
    m_post_rst = 1'b0;
    if ($countones(PSEL) > 1) v[0] = 1'b1;
    if (m_stage == 0) begin
      if (sel && PENABLE) v[1] = 1'b1;
      else if (sel) begin
        c_addr = PADDR; c_wr = PWRITE; c_data = PWDATA; c_sel = PSEL; nxt = 1;
      end
    end else if (sel && PENABLE) begin
      if (PADDR != c_addr || PWRITE != c_wr || PSEL != c_sel || (c_wr && PWDATA != c_data))
        v[3] = 1'b1;
      if (PREADY) done = 1'b1;
      else begin
        m_waits++;
        if (m_waits == MW) v[4] = 1'b1;
        nxt = 2;
      end
    end else begin
      if (m_stage == 1) v[2] = 1'b1;
      else v[7] = 1'b1;
      if (m_stage == 1 && sel) begin
        c_addr = PADDR; c_wr = PWRITE; c_data = PWDATA; c_sel = PSEL; nxt = 1;
      end
    end
    if (nxt != 2) m_waits = 0;
    m_stage = nxt;
    if (PSLVERR && !done) v[6] = 1'b1;
    if (clear_i) begin
      m_flags = 8'h00; m_first = 3'd0; m_wr = 0; m_rd = 0; m_se = 0;
    end
    if (done) begin
      if (c_wr) m_wr++;
      else m_rd++;
      if (PSLVERR) m_se++;
    end
    if (m_flags == 8'h00 && v != 8'h00) begin
      for (int i = 7; i >= 0; i--) if (v[i]) m_first = 3'(i);
    end
    m_flags = m_flags | v;
    m_pulse = (v != 8'h00);
  endtask

  task automatic compare_all();
    if (pulse_a) pulse_seen++;
    check("flags_a", flags_a, m_flags);
    check("pulse_a", pulse_a, m_pulse);
    check("first_a", first_a, m_first);
    check("state_a", st_a, m_stage);
    check("wr_a", wr_a, sat(m_wr, CWA));
    check("rd_a", rd_a, sat(m_rd, CWA));
    check("slverr_a", se_a, sat(m_se, CWA));
    check("flags_b", flags_b, m_flags);
    check("pulse_b", pulse_b, m_pulse);
    check("first_b", first_b, m_first);
    check("state_b", st_b, m_stage);
    check("wr_b", wr_b, sat(m_wr, CWB));
    check("rd_b", rd_b, sat(m_rd, CWB));
    check("slverr_b", se_b, sat(m_se, CWB));
  endtask

  // Per-cycle compare: update the model at the sampling edge, check just after.
  initial begin
    forever begin
      @(posedge PCLK);
      model_step();
      #1;
      compare_all();
    end
  end

  task automatic drive(input logic [3:0] sel, input logic en, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic rdy, input logic err);
    PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PWDATA = data;
    PREADY = rdy; PSLVERR = err;
    @(negedge PCLK);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    idle(1);
    clear_i = 1'b0;
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    // Reset with non-zero read data on release.
    PRDATA = 32'hDEAD_BEEF;
    #1 PRESETn = 1'b0;
    @(negedge PCLK);
    check("rst_state", st_a, 64'd0);
    check("rst_flags", flags_a, 64'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    idle(1);
    PRDATA = 32'h0;
    check("lit_rst_rdata_flags", flags_a, 64'h20);
    check("lit_rst_rdata_first", first_a, 64'd5);
    check("lit_rst_rdata_pulse", pulse_a, 64'd1);
    idle(1);
    check("lit_rst_rdata_pulse_drop", pulse_a, 64'd0);

    // Legal write with two wait states, then read with slave error.
    do_clear();
    drive(4'b0001, 1'b0, 1'b1, 32'h10, 32'hA5, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b1, 32'h10, 32'hA5, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b1, 32'h10, 32'hA5, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b1, 32'h10, 32'hA5, 1'b1, 1'b0);
    idle(1);
    drive(4'b0001, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1);
    idle(1);
    check("lit_legal_flags", flags_a, 64'h0);
    check("lit_legal_wr", wr_a, 64'd1);
    check("lit_legal_rd", rd_a, 64'd1);
    check("lit_legal_slverr", se_a, 64'd1);

    // Enable without setup, then address change during the wait.
    do_clear();
    drive(4'b0001, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    idle(1);
    drive(4'b0001, 1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1, 1'b0);
    idle(1);
    check("lit_unstable_flags", flags_a, 64'h0A);
    check("lit_unstable_first", first_a, 64'd1);

    // Twenty wait states: timeout on the sixteenth.
    do_clear();
    pulse_seen = 0;
    drive(4'b0001, 1'b0, 1'b1, 32'h40, 32'h1234, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      drive(4'b0001, 1'b1, 1'b1, 32'h40, 32'h1234, 1'b0, 1'b0);
      if (i == 15) check("lit_timeout_before", flags_a, 64'h0);
      if (i == 16) check("lit_timeout_at", flags_a, 64'h10);
    end
    drive(4'b0001, 1'b1, 1'b1, 32'h40, 32'h1234, 1'b1, 1'b0);
    idle(2);
    check("lit_timeout_flags", flags_a, 64'h10);
    check("lit_timeout_first", first_a, 64'd4);
    check("lit_timeout_pulses", pulse_seen, 64'd1);

    // Multi-hot select; clear in the same cycle the write completes.
    drive(4'b0101, 1'b0, 1'b1, 32'h50, 32'h77, 1'b0, 1'b0);
    clear_i = 1'b1;
    drive(4'b0101, 1'b1, 1'b1, 32'h50, 32'h77, 1'b1, 1'b0);
    clear_i = 1'b0;
    idle(1);
    check("lit_clear_flags", flags_a, 64'h01);
    check("lit_clear_first", first_a, 64'd0);
    check("lit_clear_wr", wr_a, 64'd1);

    // Five back-to-back reads.
    do_clear();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0010, 1'b0, 1'b0, 32'h100 + 32'(i), 32'h0, 1'b0, 1'b0);
      drive(4'b0010, 1'b1, 1'b0, 32'h100 + 32'(i), 32'h0, 1'b1, 1'b0);
    end
    idle(1);
    check("lit_b2b_flags", flags_a, 64'h0);
    check("lit_b2b_rd_a", rd_a, 64'd5);
    check("lit_b2b_rd_b_sat", rd_b, 64'd3);

    // Setup without access, aborted access, stray slave error.
    do_clear();
    drive(4'b0001, 1'b0, 1'b0, 32'h60, 32'h0, 1'b0, 1'b0);
    idle(1);
    drive(4'b0001, 1'b0, 1'b0, 32'h64, 32'h0, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b0, 32'h64, 32'h0, 1'b0, 1'b0);
    idle(1);
    drive(4'b0000, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(1);
    check("lit_misc_flags", flags_a, 64'hC4);
    check("lit_misc_first", first_a, 64'd2);

    // Reset in the middle of a transfer.
    do_clear();
    drive(4'b0001, 1'b0, 1'b1, 32'h70, 32'h9, 1'b0, 1'b0);
    drive(4'b0001, 1'b1, 1'b1, 32'h70, 32'h9, 1'b0, 1'b0);
    PRESETn = 1'b0;
    PSEL = 4'b0000; PENABLE = 1'b0; PREADY = 1'b0;
    #1;
    check("lit_async_rst_state", st_a, 64'd0);
    idle(2);
    PRESETn = 1'b1;
    idle(3);
    check("lit_midrst_flags", flags_a, 64'h0);
    check("lit_midrst_wr", wr_a, 64'd0);
    check("lit_midrst_state", st_a, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
